// File: rtl/seq_signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    // The helper works at a fixed maximum width; callers zero-extend and truncate.
    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] apply_sign(input logic [MAX_WIDTH-1:0] mag,
                                                        input logic               neg);
        return neg ? (-mag) : mag;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Request/result bundle between a requester and the sequential signed divider.
interface seq_signed_divider_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_signed_divider_restore_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           borrow;
    logic           unused_diff_msb;

    assign rem_sh = {rem_in, quo_in[WIDTH-1]};
    assign {borrow, diff} = {1'b0, rem_sh} - {2'b00, dmag};

    // The remainder stays below the divisor magnitude, so the kept trial never needs its top bit.
    assign unused_diff_msb = diff[WIDTH];

    assign rem_out = borrow ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_signed_divider.sv
// Signed restoring divider, one quotient bit per clock, with overflow/zero flags.
// Latency: done pulses WIDTH+1 clocks after the accept edge, for every operand pair.
// Backpressure: start is ignored while busy; no request queueing.
module seq_signed_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_signed_divider_if.slave  bus
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dmag_q, dvd_q;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic             dvd_neg_q, dsr_neg_q, dz_q, ov_q;
    logic [WIDTH-1:0] q_res, r_res;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             overflow_q, div_by_zero_q, done_q;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dmag    (dmag_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Divide-by-zero bypasses the iterated result; overflow falls out of the magnitude path.
    always_comb begin
        q_res = WIDTH'(apply_sign(MAX_WIDTH'(quo_q), dvd_neg_q ^ dsr_neg_q));
        r_res = WIDTH'(apply_sign(MAX_WIDTH'(rem_q), dvd_neg_q));
        if (dz_q) begin
            q_res = '1;
            r_res = dvd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dmag_q        <= '0;
            dvd_q         <= '0;
            dvd_neg_q     <= 1'b0;
            dsr_neg_q     <= 1'b0;
            dz_q          <= 1'b0;
            ov_q          <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    quo_q     <= WIDTH'(apply_sign(MAX_WIDTH'(bus.dividend), bus.dividend[WIDTH-1]));
                    dmag_q    <= WIDTH'(apply_sign(MAX_WIDTH'(bus.divisor), bus.divisor[WIDTH-1]));
                    rem_q     <= '0;
                    dvd_q     <= bus.dividend;
                    dvd_neg_q <= bus.dividend[WIDTH-1];
                    dsr_neg_q <= bus.divisor[WIDTH-1];
                    dz_q      <= (bus.divisor == '0);
                    ov_q      <= (bus.dividend == MIN_VAL) && (bus.divisor == '1);
                    cnt_q     <= CNT_W'(WIDTH);
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    quotient_q    <= q_res;
                    remainder_q   <= r_res;
                    overflow_q    <= ov_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed vector bench for seq_signed_divider at WIDTH=4.
module tb_seq_signed_divider;

    localparam int W  = 4;
    localparam int NV = 13;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ov;
        logic         dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[NV];

    seq_signed_divider_if #(.WIDTH(W)) bus();

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge while the divider is idle; returns edges from accept to done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(inout int lat);
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{4'd7,     4'd2,     4'd3,     4'd1,     1'b0, 1'b0};
        vecs[1]  = '{4'(-7),   4'd2,     4'(-3),   4'(-1),   1'b0, 1'b0};
        vecs[2]  = '{4'd7,     4'(-2),   4'(-3),   4'd1,     1'b0, 1'b0};
        vecs[3]  = '{4'(-7),   4'(-2),   4'd3,     4'(-1),   1'b0, 1'b0};
        vecs[4]  = '{4'(-8),   4'd3,     4'(-2),   4'(-2),   1'b0, 1'b0};
        vecs[5]  = '{4'(-8),   4'(-1),   4'(-8),   4'd0,     1'b1, 1'b0};
        vecs[6]  = '{4'd5,     4'd0,     4'(-1),   4'd5,     1'b0, 1'b1};
        vecs[7]  = '{4'd0,     4'd3,     4'd0,     4'd0,     1'b0, 1'b0};
        vecs[8]  = '{4'(-8),   4'(-8),   4'd1,     4'd0,     1'b0, 1'b0};
        vecs[9]  = '{4'd3,     4'(-8),   4'd0,     4'd3,     1'b0, 1'b0};
        vecs[10] = '{4'(-8),   4'd1,     4'(-8),   4'd0,     1'b0, 1'b0};
        vecs[11] = '{4'd7,     4'd7,     4'd1,     4'd0,     1'b0, 1'b0};
        vecs[12] = '{4'(-1),   4'd0,     4'(-1),   4'(-1),   1'b0, 1'b1};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_done",  32'(bus.done),        32'd0);
        chk("rst_quo",   32'(bus.quotient),    32'd0);
        chk("rst_rem",   32'(bus.remainder),   32'd0);
        chk("rst_ov",    32'(bus.overflow),    32'd0);
        chk("rst_dz",    32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat),             32'd5);
            chk($sformatf("v%0d_quo", i),     32'(bus.quotient),    32'(vecs[i].q));
            chk($sformatf("v%0d_rem", i),     32'(bus.remainder),   32'(vecs[i].r));
            chk($sformatf("v%0d_ov", i),      32'(bus.overflow),    32'(vecs[i].ov));
            chk($sformatf("v%0d_dz", i),      32'(bus.div_by_zero), 32'(vecs[i].dz));
            chk($sformatf("v%0d_busy_done", i), 32'(bus.busy),      32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(bus.done),     32'd0);
        end

        // start held high with new operands while busy must not disturb the first division
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        @(posedge clk); #1;
        bus.dividend = 4'(-3);
        bus.divisor  = 4'd1;
        lat = 0;
        repeat (3) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(lat);
        chk("hold_latency", 32'(lat),          32'd5);
        chk("hold_quo",     32'(bus.quotient),  32'd3);
        chk("hold_rem",     32'(bus.remainder), 32'd1);
        @(posedge clk); #1;
        chk("hold_no_second", 32'(bus.busy), 32'd0);

        // back-to-back: accept a new request in the done cycle
        do_op(4'd7, 4'd2, lat);
        chk("b2b_first_latency", 32'(lat), 32'd5);
        bus.start    = 1'b1;
        bus.dividend = 4'd6;
        bus.divisor  = 4'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_done_drop",  32'(bus.done),     32'd0);
        chk("b2b_busy",       32'(bus.busy),     32'd1);
        chk("b2b_quo_held",   32'(bus.quotient), 32'd3);
        lat = 0;
        wait_done(lat);
        chk("b2b_latency", 32'(lat),          32'd5);
        chk("b2b_quo",     32'(bus.quotient),  32'd1);
        chk("b2b_rem",     32'(bus.remainder), 32'd2);
        @(posedge clk); #1;

        // reset two cycles into CALC aborts the division and clears the held results
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy),        32'd0);
        chk("arst_done", 32'(bus.done),        32'd0);
        chk("arst_quo",  32'(bus.quotient),    32'd0);
        chk("arst_rem",  32'(bus.remainder),   32'd0);
        chk("arst_ov",   32'(bus.overflow),    32'd0);
        chk("arst_dz",   32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        do_op(4'd7, 4'd3, lat);
        chk("post_rst_latency", 32'(lat),          32'd5);
        chk("post_rst_quo",     32'(bus.quotient),  32'd2);
        chk("post_rst_rem",     32'(bus.remainder), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
